// File: rtl/program_counter_stack.sv
// Program counter with a hardware return-address stack.
// Commands per cycle, highest priority first: call, ret, load, count.
// Optional macro PC_STACK_GUARD_EN: when defined, a call on a full stack or a
// ret on an empty stack is blocked and raises a sticky o_err. When undefined,
// such a call still jumps but drops its return address, such a ret sends the
// PC to 0, and o_err is tied low.
module program_counter_stack #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_count,
    input  logic             i_call,
    input  logic             i_ret,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_bus,
    output logic [WIDTH-1:0] o_bus,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_tc,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_err
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);
    localparam logic [SPW-1:0]   SP_MAX = SPW'(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] succ;
    logic [IDXW-1:0]  wr_idx, top_idx;
    logic             push;
    logic             empty, full;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_MAX);
    assign wr_idx  = IDXW'(sp_q);
    assign top_idx = IDXW'(sp_q - 1'b1);

    // Loaded values may sit above the wrap point, so compare with >= rather than ==.
    assign succ = (pc_q >= TOP) ? '0 : pc_q + 1'b1;

    assign o_pc    = pc_q;
    assign o_bus   = i_enable ? pc_q : '0;
    assign o_tc    = i_count & (pc_q == TOP);
    assign o_empty = empty;
    assign o_full  = full;

    // Next-state selection: one command per cycle, call wins over everything.
    always_comb begin
        pc_d = pc_q;
        sp_d = sp_q;
        push = 1'b0;
        if (i_call) begin
            if (!full) begin
                push = 1'b1;
                sp_d = sp_q + 1'b1;
                pc_d = i_bus;
            end else begin
`ifndef PC_STACK_GUARD_EN
                // Jump anyway; the return address is lost.
                pc_d = i_bus;
`endif
            end
        end else if (i_ret) begin
            if (!empty) begin
                pc_d = stack_q[top_idx];
                sp_d = sp_q - 1'b1;
            end else begin
`ifndef PC_STACK_GUARD_EN
                pc_d = '0;
`endif
            end
        end else if (i_load) begin
            pc_d = i_bus;
        end else if (i_count) begin
            pc_d = succ;
        end
    end

    // PC and stack pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= '0;
            sp_q <= '0;
        end else begin
            pc_q <= pc_d;
            sp_q <= sp_d;
        end
    end

    // Stack storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge i_clk) begin
        if (push) stack_q[wr_idx] <= succ;
    end

`ifdef PC_STACK_GUARD_EN
    logic err_q;
    logic fault;

    assign fault = (i_call & full) | (~i_call & i_ret & empty);
    assign o_err = err_q;

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) err_q <= 1'b0;
        else if (fault) err_q <= 1'b1;
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: doc/program_counter_stack.md
PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: bit width of the program counter and bus.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of return-stack entries, which SHALL be at least 1.
REQ-003 The block SHALL have parameter MODULUS, default 2**WIDTH: count wrap value, with 2 <= MODULUS <= 2**WIDTH.
REQ-004 Port i_clk SHALL be an input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port i_rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port i_load SHALL be an input, 1 bit: load the PC from i_bus.
REQ-007 Port i_count SHALL be an input, 1 bit: increment the PC.
REQ-008 Port i_call SHALL be an input, 1 bit: push the return address and jump to i_bus.
REQ-009 Port i_ret SHALL be an input, 1 bit: pop the top of stack into the PC.
REQ-010 Port i_enable SHALL be an input, 1 bit: drive the PC onto o_bus.
REQ-011 Port i_bus SHALL be an input, WIDTH bits: load or call target.
REQ-012 Port o_bus SHALL be an output, WIDTH bits: PC when i_enable=1, else 0.
REQ-013 Port o_pc SHALL be an output, WIDTH bits: current PC, always visible.
REQ-014 Port o_tc SHALL be an output, 1 bit: terminal count, equal to i_count AND (PC == MODULUS-1).
REQ-015 Port o_empty SHALL be an output, 1 bit: stack holds 0 entries.
REQ-016 Port o_full SHALL be an output, 1 bit: stack holds DEPTH entries.
REQ-017 Port o_err SHALL be an output, 1 bit: sticky stack fault flag.

Function
REQ-018 o_bus, o_tc, o_empty and o_full SHALL be combinational from registered state and inputs; the PC and stack SHALL update one cycle after their command is sampled.
REQ-019 The block SHALL apply one command per cycle, priority highest first: i_call, i_ret, i_load, i_count; lower-priority requests in the same cycle SHALL be ignored.
REQ-020 Count SHALL set PC to 0 when PC >= MODULUS-1, else PC+1.
REQ-021 Load SHALL set PC to i_bus unmodified, including values >= MODULUS; the next count then SHALL wrap to 0.
REQ-022 Call, when not full, SHALL push the count-successor of PC (per REQ-020), set PC to i_bus, and increment the stack pointer.
REQ-023 Ret, when not empty, SHALL set PC to the top entry and decrement the stack pointer.
REQ-024 Simultaneous i_call and i_ret SHALL execute the call only.
REQ-025 With no command asserted, the PC and stack SHALL hold.
REQ-026 The stack pointer SHALL range 0..DEPTH and be $clog2(DEPTH+1) bits wide.

Reset
REQ-027 While i_rst_n=0, the block SHALL force PC=0, stack pointer=0, o_err=0, o_empty=1, o_full=0 (o_full=1 is never possible in reset), o_bus=0 and o_tc=0, regardless of i_clk.
REQ-028 Assertion of i_rst_n mid-call or mid-ret SHALL discard that command.
REQ-029 After release, the first command SHALL be honoured on the first rising edge with i_rst_n=1.
REQ-030 Stack entry contents SHALL need no reset; they SHALL be unobservable while empty.

Configuration
REQ-031 Macro PC_STACK_GUARD_EN SHALL compile stack fault protection in or out.
REQ-032 With PC_STACK_GUARD_EN defined, a call when full SHALL leave the PC and stack unchanged and set o_err.
REQ-033 With PC_STACK_GUARD_EN defined, a ret when empty SHALL leave the PC unchanged and set o_err.
REQ-034 With PC_STACK_GUARD_EN defined, o_err SHALL stay 1 until reset.
REQ-035 Without PC_STACK_GUARD_EN, a call when full SHALL still jump to i_bus, but the return address SHALL be dropped and the stack left unchanged.
REQ-036 Without PC_STACK_GUARD_EN, a ret when empty SHALL set PC=0.
REQ-037 Without PC_STACK_GUARD_EN, o_err SHALL be tied to 0.

Verification
REQ-038 The bench SHALL check reset and count (WIDTH=4, MODULUS=16): hold i_rst_n=0 then release, i_count=1 for 17 cycles -> PC 0,1..15,0,1; o_tc=1 only while PC=15.
REQ-039 The bench SHALL check MODULUS=10 with load: load 12, then count -> PC=12, then 0; count from 9 -> 0 with o_tc=1.
REQ-040 The bench SHALL check nested call and ret: PC=3, call 8, count, call 12, ret, ret -> PC 8, 9, 12, 10, 4; o_empty returns to 1.
REQ-041 The bench SHALL check priority: i_call=i_ret=i_load=i_count=1 with i_bus=5 at PC=2 -> PC=5, stack top=3, one entry.
REQ-042 The bench SHALL check overflow with PC_STACK_GUARD_EN defined: 4 calls then a 5th call to 7 -> PC unchanged, o_full=1, o_err=1; o_err stays 1 until reset.
REQ-043 The bench SHALL check empty ret without PC_STACK_GUARD_EN: ret at PC=6 with empty stack -> PC=0, o_err=0.
REQ-044 The bench SHALL check bus output: toggle i_enable at PC=9 -> o_bus alternates 9 and 0 with no clock edge needed.
